// File: rtl/mul_pkg.sv
// mul_pkg: shared types and constants for the multiply-accumulate stage
package mul_pkg;
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    localparam int DEF_PROD_W = 64;
    localparam logic [DEF_PROD_W-1:0] SAT_MAX = {1'b0, {(DEF_PROD_W-1){1'b1}}};
    localparam logic [DEF_PROD_W-1:0] SAT_MIN = {1'b1, {(DEF_PROD_W-1){1'b0}}};
endpackage

// File: rtl/sat_add.sv
// sat_add: combinational signed saturating adder
module sat_add
    import mul_pkg::*;
#(
    parameter int W = DEF_PROD_W
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] sum,
    output logic                sat_event
);
    logic signed [W-1:0] raw;
    assign raw       = a + b;
    assign sat_event = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);
    assign sum       = !sat_event ? raw
                     : a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
endmodule

// File: rtl/mul_accumulator.sv
// mul_accumulator: accumulates LEN signed products into a saturating sum
module mul_accumulator
    import mul_pkg::*;
#(
    parameter int LEN    = 8,
    parameter int PROD_W = DEF_PROD_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       prod_valid,
    input  logic signed [PROD_W-1:0]   prod,
    input  logic                       prod_ovf,
    output logic                       prod_ready,
    output logic                       acc_valid,
    input  logic                       acc_ready,
    output logic signed [PROD_W-1:0]   acc_out,
    output logic                       acc_ovf,
    output logic                       busy,
    output logic [$clog2(LEN+1)-1:0]   count
);
    localparam int CW = $clog2(LEN+1);
    localparam logic [CW-1:0] LAST = CW'(LEN-1);
    state_t state;
    logic signed [PROD_W-1:0] sum;
    logic sat;
    sat_add #(.W(PROD_W)) u_add (
        .a(acc_out),
        .b(prod),
        .sum(sum),
        .sat_event(sat)
    );
    assign prod_ready = state == ACCUM;
    assign acc_valid  = state == DONE;
    assign busy       = state != IDLE;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            acc_out <= '0;
            acc_ovf <= 1'b0;
            count   <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    acc_out <= '0;
                    acc_ovf <= 1'b0;
                    count   <= '0;
                    state   <= ACCUM;
                end
                ACCUM: if (prod_valid) begin
                    acc_out <= sum;
                    acc_ovf <= acc_ovf | prod_ovf | sat;
                    count   <= count + 1'b1;
                    if (count == LAST) state <= DONE;
                end
                DONE: if (acc_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_accumulator.sv
// tb_mul_accumulator: scoreboard bench over LEN=8, LEN=2 and LEN=1 instances
module tb_mul_accumulator;
    typedef struct {
        logic [63:0] acc;
        logic        ovf;
        int          cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start[3], pv[3], povf[3], ar[3], pr[3], av[3], aovf[3], busy[3];
    logic [63:0] prod[3], acc_out[3];
    logic [63:0] vec[8];
    logic [7:0] vovf;
    exp_t q[3][$];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : gi
        localparam int L = g == 0 ? 8 : g == 1 ? 2 : 1;
        logic [$clog2(L+1)-1:0] cnt;
        mul_accumulator #(.LEN(L), .PROD_W(64)) dut (
            .clk(clk),
            .reset(reset),
            .start(start[g]),
            .prod_valid(pv[g]),
            .prod(prod[g]),
            .prod_ovf(povf[g]),
            .prod_ready(pr[g]),
            .acc_valid(av[g]),
            .acc_ready(ar[g]),
            .acc_out(acc_out[g]),
            .acc_ovf(aovf[g]),
            .busy(busy[g]),
            .count(cnt)
        );
        always @(negedge clk) begin
            exp_t e;
            if (reset && av[g] && ar[g]) begin
                if (q[g].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected result inst %0d: got %h", g, acc_out[g]);
                end else begin
                    e = q[g].pop_front();
                    chk($sformatf("acc_out inst %0d", g), acc_out[g], e.acc);
                    chk($sformatf("acc_ovf inst %0d", g), 64'(aovf[g]), 64'(e.ovf));
                    chk($sformatf("count inst %0d", g), 64'(cnt), 64'(e.cnt));
                end
            end
        end
    end

    task automatic do_start(int i);
        @(posedge clk); #1 start[i] = 1'b1;
        @(posedge clk); #1 start[i] = 1'b0;
        chk("prod_ready after start", 64'(pr[i]), 64'(1));
        chk("busy after start", 64'(busy[i]), 64'(1));
    endtask

    task automatic beat(int i, logic [63:0] p, logic o);
        pv[i] = 1'b1;
        prod[i] = p;
        povf[i] = o;
        @(posedge clk); #1;
        pv[i] = 1'b0;
        povf[i] = 1'b0;
    endtask

    task automatic take(int i);
        ar[i] = 1'b1;
        @(posedge clk); #1 ar[i] = 1'b0;
        chk("acc_valid drop", 64'(av[i]), 64'(0));
    endtask

    task automatic run(int i, int n, logic [63:0] ea, logic eo, bit rel);
        q[i].push_back('{ea, eo, n});
        do_start(i);
        for (int k = 0; k < n; k++) beat(i, vec[k], vovf[k]);
        chk("acc_valid after last beat", 64'(av[i]), 64'(1));
        if (rel) take(i);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            start[i] = 0; pv[i] = 0; povf[i] = 0; ar[i] = 0; prod[i] = '0;
        end
        vovf = '0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("reset acc_out", acc_out[i], 64'(0));
            chk("reset acc_valid", 64'(av[i]), 64'(0));
            chk("reset prod_ready", 64'(pr[i]), 64'(0));
            chk("reset busy", 64'(busy[i]), 64'(0));
        end
        @(negedge clk) reset = 1'b1;

        vec = '{-64'sd35, 64'sd6, 64'sd48, -64'sd45, 64'sd0, 64'sd10, 64'sd24, 64'sd7};
        run(0, 8, 64'sd15, 1'b0, 1'b1);

        vec[0] = 64'h4000_0000_0000_0000; vec[1] = 64'h4000_0000_0000_0000;
        run(1, 2, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        vec[0] = 64'h8000_0000_0000_0000; vec[1] = -64'sd1;
        run(1, 2, 64'h8000_0000_0000_0000, 1'b1, 1'b1);

        q[0].push_back('{64'sd8, 1'b1, 8});
        do_start(0);
        for (int k = 0; k < 8; k++) begin
            beat(0, 64'sd1, k == 2);
            prod[0] = 64'hDEAD_BEEF_DEAD_BEEF;
            if (k < 7) begin
                repeat (2) @(posedge clk);
                #1 chk("count holds in gap", 64'(gi[0].cnt), 64'(k + 1));
            end
        end
        chk("acc_valid after gapped run", 64'(av[0]), 64'(1));
        take(0);

        vec = '{-64'sd35, 64'sd6, 64'sd48, -64'sd45, 64'sd0, 64'sd10, 64'sd24, 64'sd7};
        run(0, 8, 64'sd15, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            start[0] = c == 2;
            @(posedge clk); #1;
            chk("backpressure acc_valid", 64'(av[0]), 64'(1));
            chk("backpressure acc_out", acc_out[0], 64'sd15);
            chk("backpressure prod_ready", 64'(pr[0]), 64'(0));
        end
        start[0] = 1'b1;
        take(0);
        start[0] = 1'b0;
        chk("idle after take with start", 64'(busy[0]), 64'(0));
        chk("acc_out held after take", acc_out[0], 64'sd15);

        do_start(0);
        for (int k = 0; k < 3; k++) beat(0, vec[k], 1'b0);
        #2 reset = 1'b0;
        #1;
        chk("async reset acc_out", acc_out[0], 64'(0));
        chk("async reset busy", 64'(busy[0]), 64'(0));
        chk("async reset prod_ready", 64'(pr[0]), 64'(0));
        chk("async reset count", 64'(gi[0].cnt), 64'(0));
        @(negedge clk) reset = 1'b1;
        run(0, 8, 64'sd15, 1'b0, 1'b1);

        vec[0] = -64'sd7;
        run(2, 1, -64'sd7, 1'b0, 1'b1);

        repeat (2) @(posedge clk);
        for (int i = 0; i < 3; i++) chk("scoreboard drained", 64'(q[i].size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
